vocab_matcher: RTL and testbench

- Synchronous successor to the gated-clock character matcher.
- Searches a writable vocabulary memory of null-terminated tokens for a packed input word; returns hit/miss and the token index.
- Sits between the tokenizer front end and the tensor-core embedding lookup.
- Single clock domain, no clock gating; explicit start/busy/done handshake.

---
 rtl/vocab_matcher.sv | 170 +++++++++++++++++
 tb/tb_vocab_matcher.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vocab_matcher.sv
// Vocabulary search engine: scans null-terminated tokens in a writable byte
// memory for a packed input word and reports hit/miss, token index and overflow.
module vocab_matcher #(
  parameter int ADDR_WIDTH  = 4,
  parameter int WORD_LENGTH = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int TOKEN_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
  output logic                              busy,
  output logic                              done,
  output logic                              match,
  output logic [TOKEN_WIDTH-1:0]            token_id,
  output logic                              overflow,
  input  logic                              vocab_we,
  input  logic [ADDR_WIDTH-1:0]             vocab_waddr,
  input  logic [DATA_WIDTH-1:0]             vocab_wdata
);

  localparam int CIW = $clog2(WORD_LENGTH + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CMP  = 3'd2,
    S_SKIP = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e                              state_q;
  logic [WORD_LENGTH*DATA_WIDTH-1:0]   word_q;
  logic [ADDR_WIDTH-1:0]               addr_q;
  logic [CIW-1:0]                      char_idx_q;
  logic [TOKEN_WIDTH-1:0]              token_q;
  logic                                skip_q;
  logic [DATA_WIDTH-1:0]               rdata_q;
  logic                                busy_q;
  logic                                done_q;
  logic                                match_q;
  logic [TOKEN_WIDTH-1:0]              token_id_q;
  logic                                overflow_q;
  logic [DATA_WIDTH-1:0]               mem_q [2**ADDR_WIDTH];

  logic [DATA_WIDTH-1:0]               cur_char_s;
  logic                                at_end_s;
  logic                                rdata_zero_s;
  logic                                char_eq_s;

  // Character at char_idx; index WORD_LENGTH is the implicit terminator.
  always_comb begin
    cur_char_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < WORD_LENGTH; i++) begin
      if (char_idx_q == CIW'(i)) begin
        cur_char_s = word_q[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        cur_char_s = cur_char_s;
      end
    end
  end

  assign at_end_s     = (addr_q == ADDR_LAST);
  assign rdata_zero_s = (rdata_q == {DATA_WIDTH{1'b0}});
  assign char_eq_s    = (rdata_q == cur_char_s);

  // Vocabulary storage: writes only while idle, synchronous read in READ.
  always_ff @(posedge clk) begin
    if (vocab_we && (state_q == S_IDLE)) begin
      mem_q[vocab_waddr] <= vocab_wdata;
    end
    if (state_q == S_READ) begin
      rdata_q <= mem_q[addr_q];
    end
  end

  // Search FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      addr_q     <= '0;
      char_idx_q <= '0;
      token_q    <= '0;
      skip_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      token_id_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            word_q     <= word;
            addr_q     <= '0;
            char_idx_q <= '0;
            token_q    <= '0;
            skip_q     <= 1'b0;
            match_q    <= 1'b0;
            token_id_q <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          state_q <= skip_q ? S_SKIP : S_CMP;
        end
        S_CMP: begin
          if (rdata_zero_s && (char_idx_q == CIW'(0))) begin
            state_q <= S_DONE;
          end else if (char_eq_s && (cur_char_s == {DATA_WIDTH{1'b0}})) begin
            match_q    <= 1'b1;
            token_id_q <= token_q;
            state_q    <= S_DONE;
          end else if (at_end_s) begin
            overflow_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            state_q <= S_READ;
            if (char_eq_s) begin
              char_idx_q <= char_idx_q + CIW'(1);
            end else if (rdata_zero_s) begin
              // Entry ended before the word did: move on to the next entry.
              token_q    <= token_q + TOKEN_WIDTH'(1);
              char_idx_q <= '0;
            end else begin
              skip_q <= 1'b1;
            end
          end
        end
        S_SKIP: begin
          if (at_end_s) begin
            overflow_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            state_q <= S_READ;
            if (rdata_zero_s) begin
              token_q    <= token_q + TOKEN_WIDTH'(1);
              char_idx_q <= '0;
              skip_q     <= 1'b0;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign match    = match_q;
  assign token_id = token_id_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_vocab_matcher.sv
// Self-checking bench for vocab_matcher: entry-level string model of the search,
// cycle-accurate compare process, directed scenarios and randomized searches.
module tb_vocab_matcher;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] word;
  logic        busy;
  logic        done;
  logic        match;
  logic [3:0]  token_id;
  logic        overflow;
  logic        vocab_we;
  logic [3:0]  vocab_waddr;
  logic [7:0]  vocab_wdata;

  vocab_matcher #(
    .ADDR_WIDTH(4), .WORD_LENGTH(3), .DATA_WIDTH(8), .TOKEN_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .word(word),
    .busy(busy), .done(done), .match(match), .token_id(token_id),
    .overflow(overflow), .vocab_we(vocab_we), .vocab_waddr(vocab_waddr),
    .vocab_wdata(vocab_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem_m [16];
  bit m_active = 1'b0;
  int m_k = 0;
  int m_n = 0;
  bit r_hit, r_ovf;
  int r_tok;
  bit h_match = 1'b0, h_ovf = 1'b0;
  int h_tok = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Search model at the level of whole entries: compare the word against each
  // token as a string and count how many bytes the scan must look at.
  function automatic void model(input logic [23:0] w, output int n, output bit hit,
                                output int tok, output bit ovf);
    logic [7:0] wc [4];
    int L, s, j, e;
    bit fin;
    for (int i = 0; i < 4; i++) wc[i] = 8'h00;
    L = 3;
    for (int i = 2; i >= 0; i--) if (w[i*8 +: 8] == 8'h00) L = i;
    for (int i = 0; i < L; i++) wc[i] = w[i*8 +: 8];
    n = 0; hit = 1'b0; tok = 0; ovf = 1'b0; s = 0; fin = 1'b0;
    while (!fin) begin
      if (s > 15) begin
        ovf = 1'b1; fin = 1'b1;
      end else if (mem_m[s] == 8'h00) begin
        n += 1; fin = 1'b1;
      end else begin
        j = 0;
        while (j < L && s + j <= 15 && mem_m[s+j] == wc[j]) j++;
        if (s + j > 15) begin
          n += 16 - s; ovf = 1'b1; fin = 1'b1;
        end else if (j == L && mem_m[s+j] == 8'h00) begin
          n += L + 1; hit = 1'b1; fin = 1'b1;
        end else if (mem_m[s+j] == 8'h00) begin
          n += j + 1; s = s + j + 1; tok++;
        end else begin
          e = s + j + 1;
          while (e <= 15 && mem_m[e] != 8'h00) e++;
          if (e > 15) begin
            n += 16 - s; ovf = 1'b1; fin = 1'b1;
          end else begin
            n += e - s + 1; s = e + 1; tok++;
          end
        end
      end
    end
  endfunction

  // Compare process: advance the timing model on each rising edge, check 1ns later.
  initial begin : compare_proc
    bit exp_done;
    bit e_match, e_ovf;
    int e_tok;
    forever begin
      @(posedge clk);
      exp_done = 1'b0;
      if (rst) begin
        m_active = 1'b0; h_match = 1'b0; h_tok = 0; h_ovf = 1'b0;
      end else if (!m_active) begin
        if (vocab_we) mem_m[vocab_waddr] = vocab_wdata;
        if (start) begin
          model(word, m_n, r_hit, r_tok, r_ovf);
          m_active = 1'b1; m_k = 0;
          h_match = 1'b0; h_tok = 0; h_ovf = 1'b0;
        end
      end else begin
        m_k++;
        if (m_k == 2*m_n + 1) begin
          m_active = 1'b0; exp_done = 1'b1;
          h_match = r_hit; h_tok = r_hit ? r_tok : 0; h_ovf = r_ovf;
        end
      end
      #1;
      if (m_active && m_k >= 2*m_n) begin
        e_match = r_hit; e_tok = r_hit ? r_tok : 0; e_ovf = r_ovf;
      end else begin
        e_match = h_match; e_tok = h_tok; e_ovf = h_ovf;
      end
      check("busy", busy, m_active);
      check("done", done, exp_done);
      check("match", match, e_match);
      check("token_id", token_id, e_tok[3:0]);
      check("overflow", overflow, e_ovf);
    end
  end

  task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    vocab_we = 1'b1; vocab_waddr = a; vocab_wdata = d;
    @(negedge clk);
    vocab_we = 1'b0;
  endtask

  // Start a search and wait for done; returns cycles from the start edge.
  task automatic run(input logic [23:0] w, input bit noise, input int poke, output int c);
    @(negedge clk);
    word = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!done && c < 200) begin
      if (noise) begin
        start = ($urandom_range(0, 7) == 0);
        vocab_we = ($urandom_range(0, 3) == 0);
        vocab_waddr = 4'($urandom_range(0, 15));
        vocab_wdata = 8'($urandom_range(0, 255));
      end else begin
        start = (c == poke);
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0; vocab_we = 1'b0;
    if (c >= 200) check("done_timeout", 32'(c), 32'd0);
  endtask

  task automatic load_common();
    logic [7:0] v [8];
    v = '{8'h61, 8'h62, 8'h00, 8'h63, 8'h61, 8'h74, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) write_mem(4'(i), (i < 8) ? v[i] : 8'h00);
  endtask

  function automatic logic [23:0] rand_word();
    logic [23:0] w;
    int len;
    len = $urandom_range(0, 3);
    for (int i = 0; i < 3; i++) begin
      if (i < len) w[i*8 +: 8] = 8'(8'h61 + $urandom_range(0, 2));
      else if (i == len) w[i*8 +: 8] = 8'h00;
      else w[i*8 +: 8] = 8'($urandom_range(1, 255));
    end
    return w;
  endfunction

  initial begin : driver
    int c;
    rst = 1'b1; start = 1'b0; word = 24'h0;
    vocab_we = 1'b0; vocab_waddr = 4'h0; vocab_wdata = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    load_common();
    // Test 1: "cat"
    run(24'h746163, 1'b0, -1, c);
    check("t1_cycles", 32'(c), 32'd15);
    check("t1_match", match, 1'b1);
    check("t1_token", token_id, 4'd1);
    check("t1_ovf", overflow, 1'b0);
    // Test 2: "ab"
    run(24'h006261, 1'b0, -1, c);
    check("t2_cycles", 32'(c), 32'd7);
    check("t2_match", match, 1'b1);
    check("t2_token", token_id, 4'd0);
    // Test 3: "ca" (prefix of "cat")
    run(24'h006163, 1'b0, -1, c);
    check("t3_cycles", 32'(c), 32'd17);
    check("t3_match", match, 1'b0);
    check("t3_token", token_id, 4'd0);
    // Test 4: "abc" with a start pulse while busy
    run(24'h636261, 1'b0, 4, c);
    check("t4_cycles", 32'(c), 32'd17);
    check("t4_match", match, 1'b0);
    repeat (3) @(negedge clk);
    check("t4_held_match", match, 1'b0);
    check("t4_no_done", done, 1'b0);
    // Test 5: memory full of 'A', no terminator anywhere
    for (int i = 0; i < 16; i++) write_mem(4'(i), 8'h41);
    run(24'h000078, 1'b0, -1, c);
    check("t5_cycles", 32'(c), 32'd33);
    check("t5_match", match, 1'b0);
    check("t5_ovf", overflow, 1'b1);
    // Test 6: reset mid-search, then a clean repeat of test 1
    load_common();
    @(negedge clk);
    word = 24'h746163; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_busy_abort", busy, 1'b0);
    check("t6_done_abort", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    run(24'h746163, 1'b0, -1, c);
    check("t6_cycles", 32'(c), 32'd15);
    check("t6_token", token_id, 4'd1);

    // Randomized vocabularies and words, with noise on start/writes while busy
    for (int it = 0; it < 40; it++) begin
      for (int a = 0; a < 16; a++) begin
        write_mem(4'(a), ($urandom_range(0, 9) < 3) ? 8'h00 : 8'(8'h61 + $urandom_range(0, 2)));
      end
      for (int k = 0; k < 4; k++) begin
        run(rand_word(), (k % 2) == 1, -1, c);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
